writeback_lsu_stage: RTL and testbench
======================================

// Module: writeback_lsu_stage
// PURPOSE
//  Parametrised writeback stage: commits ALU/link results and extended load data to the register file.
//  Sits between memory stage and regfile. Adds valid/ready, variable-latency load responses, flush and timeout.
//  Supports RV32/RV64 load widths and sign-extends W-ops when XLEN=64.
// PARAMETERS
//  XLEN     32   datapath width; 32 or 64 only (64 enables LD/LWU/OP-32/OP-IMM-32)
//  TIMEOUT  255  max WAIT cycles before a load is abandoned; 0 = never time out
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     asynchronous, active-low reset
//  in_valid_i      in   1     instr/alu_result valid from memory stage
//  in_ready_o      out  1     stage can accept; comb: state==IDLE && !flush_i
//  instr_i         in   32    RISC-V instruction word
//  alu_result_i    in   XLEN  ALU result, load address or link address
//  mem_rsp_valid_i in   1     load data valid (accepted only in WAIT)
//  mem_rsp_data_i  in   XLEN  aligned memory word containing load data
//  flush_i         in   1     kill pending/incoming instruction
//  rf_we_o         out  1     regfile write enable, 1-cycle pulse per commit
//  rf_rd_o         out  5     destination register
//  rf_data_o       out  XLEN  write data
//  busy_o          out  1     comb: state==WAIT
//  pending_rd_o    out  5     rd of outstanding load (0 when IDLE), for hazard stall
//  timeout_o       out  1     1-cycle pulse when a load times out
//  trap_o          out  1     misaligned-load trap pulse (WB_MISALIGN_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all outputs 0. Acceptance: in_valid_i && in_ready_o at posedge.
//  Commits writing rd: LUI, AUIPC, JAL, JALR, OP-IMM, OP, plus OP-32/OP-IMM-32 when XLEN=64.
//  - These register alu_result_i into rf_data_o with 1-cycle latency.
//  - W-ops sign-extend alu_result_i[31:0].
//  Other opcodes and rd==0: accepted, no write (we=0, rd=0, data=0).
//  Cycles without commit: rf_we_o=0, rf_rd_o=0, rf_data_o=0.
//  LOAD (opcode 0000011) accepted: IDLE->WAIT; latch rd, funct3 and byte offset.
//  - Byte offset = alu_result_i[$clog2(XLEN/8)-1:0].
//  WAIT: in_ready_o=0, busy_o=1, pending_rd_o=rd. Counter increments each WAIT cycle.
//  WAIT with mem_rsp_valid_i: select lane by offset, then extend:
//  - LB/LH/LW: sign-extend. LBU/LHU/LWU: zero-extend. LD: full word.
//  - Commit on the next posedge, state->IDLE.
//  - Earliest response is the cycle after acceptance; mem_rsp_valid_i in IDLE is ignored.
//  Width rules:
//  - funct3 LD(011) and LWU(110) are legal only when XLEN=64; otherwise treated as no-write.
//  - funct3 111 is always no-write.
//  Timeout: counter==TIMEOUT-1 in WAIT without response -> timeout_o pulse, no write, IDLE, counter=0.
//  Flush: flush_i has priority over mem_rsp_valid_i and timeout.
//  - In WAIT: drop load, no write, IDLE next cycle.
//  - In IDLE: nothing accepted that cycle.
//  Back-to-back: the cycle after a load commit the stage is IDLE and can accept again.
//  Misalignment: LH/LHU offset[0]!=0; LW/LWU offset[1:0]!=0; LD offset[2:0]!=0.
//  Reset mid-WAIT: immediate IDLE, outputs 0, pending load discarded.
// CONFIGURATION
//  WB_MISALIGN_TRAP_EN defined:
//  - Misaligned load on acceptance: no WAIT entered, no write.
//  - trap_o pulses 1 cycle on the next posedge; in_ready_o stays 1.
//  WB_MISALIGN_TRAP_EN undefined:
//  - Misaligned load waits for its response, then commits rd with data 0 (we=1).
//  - trap_o tied to 0.
// TESTING
//  XLEN=32, LB x5 at addr 0x103, rsp 0x80FF_1234 two cycles later -> we=1, rd=5, data=0xFFFF_FF80.
//  XLEN=32, ADD x7, alu 0xDEAD_BEEF, valid 1 cycle -> next cycle we=1, rd=7, data=0xDEAD_BEEF.
//  ADD x0 -> we=0 and no other effect.
//  LW x3 accepted, no rsp, TIMEOUT=4 -> busy_o=1 for 4 cycles, then timeout_o pulse, we=0, in_ready_o=1.
//  LHU x9 in WAIT, flush_i and mem_rsp_valid_i same cycle -> no write, IDLE next cycle, pending_rd_o=0.
//  XLEN=64, LWU x4 at offset 4, rsp 0xF000_0001_0000_0000 -> data=0x0000_0000_F000_0001.
//  LH at addr 0x1 -> TRAP_EN: trap_o=1 next cycle, no WAIT; else after rsp, we=1 with data 0.

Source files
------------

// File: rtl/writeback_lsu_stage_if.sv
// rtl/writeback_lsu_stage_if.sv - memory-stage handoff and load-response bundle for the writeback stage
interface writeback_lsu_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] alu_result_i;
    logic            mem_rsp_valid_i;
    logic [XLEN-1:0] mem_rsp_data_i;
    logic            flush_i;

    modport master (
        output in_valid_i, instr_i, alu_result_i, mem_rsp_valid_i, mem_rsp_data_i, flush_i,
        input  in_ready_o
    );

    modport slave (
        input  in_valid_i, instr_i, alu_result_i, mem_rsp_valid_i, mem_rsp_data_i, flush_i,
        output in_ready_o
    );
endinterface

// File: rtl/writeback_lsu_stage.sv
// rtl/writeback_lsu_stage.sv - writeback stage committing ALU results and extended loads; WB_MISALIGN_TRAP_EN enables misaligned-load traps
module writeback_lsu_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    writeback_lsu_stage_if.slave  bus,
    output logic                  rf_we_o,
    output logic [4:0]            rf_rd_o,
    output logic [XLEN-1:0]       rf_data_o,
    output logic                  busy_o,
    output logic [4:0]            pending_rd_o,
    output logic                  timeout_o,
    output logic                  trap_o
);
    localparam int OW = $clog2(XLEN/8);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [4:0]        r_ld_rd, w_ld_rd_nxt;
    logic [2:0]        r_ld_f3, w_ld_f3_nxt;
    logic [OW-1:0]     r_ld_off, w_ld_off_nxt;
    logic              r_ld_mis, w_ld_mis_nxt;
    logic              r_we, w_we_nxt;
    logic [4:0]        r_rd, w_rd_nxt;
    logic [XLEN-1:0]   r_data, w_data_nxt;
    logic              r_to, w_to_nxt;
`ifdef WB_MISALIGN_TRAP_EN
    logic              r_trap, w_trap_nxt;
`endif

    logic [6:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [2:0]        w_f3;
    logic [OW-1:0]     w_off;
    logic [OW-1:0]     w_mask;
    logic              w_accept, w_is_load, w_f3_legal, w_is_wop, w_is_alu_wr, w_mis;
    logic [XLEN-1:0]   w_alu_data, w_sh, w_ext;
    logic              w_unused_instr;

    assign w_opcode   = bus.instr_i[6:0];
    assign w_rd       = bus.instr_i[11:7];
    assign w_f3       = bus.instr_i[14:12];
    assign w_off      = bus.alu_result_i[OW-1:0];
    assign w_unused_instr = ^bus.instr_i[31:15];

    assign bus.in_ready_o = (r_state == S_IDLE) && !bus.flush_i;
    assign w_accept       = bus.in_valid_i && bus.in_ready_o;

    assign w_is_load  = (w_opcode == OPC_LOAD);
    // LD and LWU only exist on RV64; 111 is never a load width
    assign w_f3_legal = (w_f3 != 3'b111) &&
                        !(((w_f3 == 3'b011) || (w_f3 == 3'b110)) && (XLEN != 64));
    assign w_is_wop   = (XLEN == 64) && ((w_opcode == OPC_OP32) || (w_opcode == OPC_OPIMM32));
    assign w_is_alu_wr = (w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                         (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR) ||
                         (w_opcode == OPC_OPIMM) || (w_opcode == OPC_OP) || w_is_wop;
    assign w_alu_data = w_is_wop ? XLEN'($signed(bus.alu_result_i[31:0])) : bus.alu_result_i;

    always_comb begin
        w_mask = '0;
        case (w_f3[1:0])
            2'b01:   w_mask = OW'(3'd1);
            2'b10:   w_mask = OW'(3'd3);
            2'b11:   w_mask = OW'(3'd7);
            default: w_mask = '0;
        endcase
    end
    assign w_mis = (w_off & w_mask) != '0;

    assign w_sh = bus.mem_rsp_data_i >> {r_ld_off, 3'b000};

    always_comb begin
        w_ext = '0;
        case (r_ld_f3)
            3'b000:  w_ext = XLEN'($signed(w_sh[7:0]));
            3'b001:  w_ext = XLEN'($signed(w_sh[15:0]));
            3'b010:  w_ext = XLEN'($signed(w_sh[31:0]));
            3'b011:  w_ext = w_sh;
            3'b100:  w_ext = XLEN'(w_sh[7:0]);
            3'b101:  w_ext = XLEN'(w_sh[15:0]);
            3'b110:  w_ext = XLEN'(w_sh[31:0]);
            default: w_ext = '0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ld_rd_nxt  = r_ld_rd;
        w_ld_f3_nxt  = r_ld_f3;
        w_ld_off_nxt = r_ld_off;
        w_ld_mis_nxt = r_ld_mis;
        w_we_nxt     = 1'b0;
        w_rd_nxt     = 5'd0;
        w_data_nxt   = '0;
        w_to_nxt     = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
        w_trap_nxt   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    if (w_is_load && w_f3_legal) begin
`ifdef WB_MISALIGN_TRAP_EN
                        if (w_mis) begin
                            w_trap_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
`else
                        w_state_nxt = S_WAIT;
`endif
                        w_ld_rd_nxt  = w_rd;
                        w_ld_f3_nxt  = w_f3;
                        w_ld_off_nxt = w_off;
                        w_ld_mis_nxt = w_mis;
                    end else if (w_is_alu_wr && (w_rd != 5'd0)) begin
                        w_we_nxt   = 1'b1;
                        w_rd_nxt   = w_rd;
                        w_data_nxt = w_alu_data;
                    end
                end
            end
            S_WAIT: begin
                if (bus.flush_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (bus.mem_rsp_valid_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    if (r_ld_rd != 5'd0) begin
                        w_we_nxt   = 1'b1;
                        w_rd_nxt   = r_ld_rd;
                        // a misaligned load that was allowed to complete writes zero
                        w_data_nxt = r_ld_mis ? '0 : w_ext;
                    end
                end else if ((TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1))) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ld_rd  <= 5'd0;
            r_ld_f3  <= 3'd0;
            r_ld_off <= '0;
            r_ld_mis <= 1'b0;
            r_we     <= 1'b0;
            r_rd     <= 5'd0;
            r_data   <= '0;
            r_to     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ld_rd  <= w_ld_rd_nxt;
            r_ld_f3  <= w_ld_f3_nxt;
            r_ld_off <= w_ld_off_nxt;
            r_ld_mis <= w_ld_mis_nxt;
            r_we     <= w_we_nxt;
            r_rd     <= w_rd_nxt;
            r_data   <= w_data_nxt;
            r_to     <= w_to_nxt;
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_trap <= 1'b0;
        else        r_trap <= w_trap_nxt;
    end
    assign trap_o = r_trap;
`else
    assign trap_o = 1'b0;
`endif

    assign rf_we_o      = r_we;
    assign rf_rd_o      = r_rd;
    assign rf_data_o    = r_data;
    assign timeout_o    = r_to;
    assign busy_o       = (r_state == S_WAIT);
    assign pending_rd_o = (r_state == S_WAIT) ? r_ld_rd : 5'd0;
endmodule

// File: tb/tb_writeback_lsu_stage.sv
// tb/tb_writeback_lsu_stage.sv - directed bench for writeback_lsu_stage at XLEN=32 and XLEN=64
module tb_writeback_lsu_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    writeback_lsu_stage_if #(.XLEN(32)) ifa();
    writeback_lsu_stage_if #(.XLEN(64)) ifb();

    logic        a_we, a_busy, a_to, a_trap;
    logic [4:0]  a_rd, a_prd;
    logic [31:0] a_data;
    logic        b_we, b_busy, b_to, b_trap;
    logic [4:0]  b_rd, b_prd;
    logic [63:0] b_data;

    writeback_lsu_stage #(.XLEN(32), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .rf_we_o(a_we), .rf_rd_o(a_rd), .rf_data_o(a_data), .busy_o(a_busy),
        .pending_rd_o(a_prd), .timeout_o(a_to), .trap_o(a_trap)
    );

    writeback_lsu_stage #(.XLEN(64), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .rf_we_o(b_we), .rf_rd_o(b_rd), .rf_data_o(b_data), .busy_o(b_busy),
        .pending_rd_o(b_prd), .timeout_o(b_to), .trap_o(b_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {17'd0, f3, rd, op};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        ifa.in_valid_i = 0; ifa.instr_i = '0; ifa.alu_result_i = '0;
        ifa.mem_rsp_valid_i = 0; ifa.mem_rsp_data_i = '0; ifa.flush_i = 0;
        ifb.in_valid_i = 0; ifb.instr_i = '0; ifb.alu_result_i = '0;
        ifb.mem_rsp_valid_i = 0; ifb.mem_rsp_data_i = '0; ifb.flush_i = 0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({a_we, a_rd, a_data} !== 38'd0) begin n_fail++; $display("FAIL reset_rf: got %b/%h/%h expected 0/00/00000000", a_we, a_rd, a_data); end
        n_checks++; if ({a_busy, a_prd, a_to, a_trap} !== 8'd0) begin n_fail++; $display("FAIL reset_status: got %b expected 00000000", {a_busy, a_prd, a_to, a_trap}); end
        n_checks++; if (ifa.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ifa.in_ready_o); end
        n_checks++; if ({b_we, b_rd, b_data, b_busy} !== 71'd0) begin n_fail++; $display("FAIL reset_b: got %b/%h/%h/%b expected zeros", b_we, b_rd, b_data, b_busy); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_alu();
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b000, 5'd7, 7'b0110011); ifa.alu_result_i = 32'hDEAD_BEEF;
        cyc();
        ifa.in_valid_i = 0;
        n_checks++; if ({a_we, a_rd, a_data} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL alu_add: got %b/%0d/%h expected 1/7/deadbeef", a_we, a_rd, a_data); end
        cyc();
        n_checks++; if ({a_we, a_rd, a_data} !== 38'd0) begin n_fail++; $display("FAIL alu_idle: got %b/%0d/%h expected 0/0/0", a_we, a_rd, a_data); end
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b000, 5'd0, 7'b0110011); ifa.alu_result_i = 32'h1234_5678;
        cyc();
        ifa.in_valid_i = 0;
        n_checks++; if ({a_we, a_rd, a_data, a_busy} !== 39'd0) begin n_fail++; $display("FAIL alu_x0: got %b/%0d/%h/%b expected 0/0/0/0", a_we, a_rd, a_data, a_busy); end
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b000, 5'd2, 7'b0110111); ifa.alu_result_i = 32'hABCD_E000;
        cyc();
        ifa.in_valid_i = 0;
        n_checks++; if ({a_we, a_rd, a_data} !== {1'b1, 5'd2, 32'hABCD_E000}) begin n_fail++; $display("FAIL alu_lui: got %b/%0d/%h expected 1/2/abcde000", a_we, a_rd, a_data); end
        cyc();
    endtask

    task automatic test_load_lb();
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b000, 5'd5, 7'b0000011); ifa.alu_result_i = 32'h0000_0103;
        cyc();
        ifa.in_valid_i = 0;
        n_checks++; if ({a_busy, a_prd, ifa.in_ready_o} !== {1'b1, 5'd5, 1'b0}) begin n_fail++; $display("FAIL lb_wait: got %b/%0d/%b expected 1/5/0", a_busy, a_prd, ifa.in_ready_o); end
        cyc();
        n_checks++; if (a_we !== 1'b0) begin n_fail++; $display("FAIL lb_nowrite: got %b expected 0", a_we); end
        ifa.mem_rsp_valid_i = 1; ifa.mem_rsp_data_i = 32'h80FF_1234;
        cyc();
        ifa.mem_rsp_valid_i = 0;
        n_checks++; if ({a_we, a_rd, a_data} !== {1'b1, 5'd5, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL lb_commit: got %b/%0d/%h expected 1/5/ffffff80", a_we, a_rd, a_data); end
        n_checks++; if ({a_busy, ifa.in_ready_o} !== 2'b01) begin n_fail++; $display("FAIL lb_idle: got %b expected 01", {a_busy, ifa.in_ready_o}); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3 [4] = '{3'b100, 3'b001, 3'b101, 3'b010};
        logic [4:0]  rd [4] = '{5'd6, 5'd8, 5'd10, 5'd11};
        logic [31:0] ad [4] = '{32'h101, 32'h102, 32'h002, 32'h004};
        logic [31:0] ex [4] = '{32'h0000_0012, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_1234};
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid_i = 1; ifa.instr_i = ins(f3[i], rd[i], 7'b0000011); ifa.alu_result_i = ad[i];
            cyc();
            ifa.in_valid_i = 0;
            n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy%0d: got %b expected 1", i, a_busy); end
            ifa.mem_rsp_valid_i = 1; ifa.mem_rsp_data_i = 32'h80FF_1234;
            cyc();
            ifa.mem_rsp_valid_i = 0;
            n_checks++; if ({a_we, a_rd, a_data} !== {1'b1, rd[i], ex[i]}) begin n_fail++; $display("FAIL b2b_commit%0d: got %b/%0d/%h expected 1/%0d/%h", i, a_we, a_rd, a_data, rd[i], ex[i]); end
            n_checks++; if (ifa.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", i, ifa.in_ready_o); end
        end
        cyc();
    endtask

    task automatic test_timeout();
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b010, 5'd3, 7'b0000011); ifa.alu_result_i = 32'h0000_0040;
        cyc();
        ifa.in_valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({a_busy, a_to, a_we} !== 3'b100) begin n_fail++; $display("FAIL to_wait%0d: got %b expected 100", i, {a_busy, a_to, a_we}); end
            cyc();
        end
        n_checks++; if ({a_busy, a_to, a_we, ifa.in_ready_o} !== 4'b0101) begin n_fail++; $display("FAIL to_pulse: got %b expected 0101", {a_busy, a_to, a_we, ifa.in_ready_o}); end
        cyc();
        n_checks++; if (a_to !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b expected 0", a_to); end
    endtask

    task automatic test_flush();
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b101, 5'd9, 7'b0000011); ifa.alu_result_i = 32'h0000_0000;
        cyc();
        ifa.in_valid_i = 0;
        ifa.flush_i = 1; ifa.mem_rsp_valid_i = 1; ifa.mem_rsp_data_i = 32'h0000_5555;
        cyc();
        ifa.flush_i = 0; ifa.mem_rsp_valid_i = 0;
        n_checks++; if ({a_we, a_busy, a_prd} !== 7'd0) begin n_fail++; $display("FAIL flush_wait: got %b/%b/%0d expected 0/0/0", a_we, a_busy, a_prd); end
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b000, 5'd7, 7'b0110011); ifa.alu_result_i = 32'h5; ifa.flush_i = 1;
        #1;
        n_checks++; if (ifa.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", ifa.in_ready_o); end
        cyc();
        ifa.in_valid_i = 0; ifa.flush_i = 0;
        n_checks++; if (a_we !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b expected 0", a_we); end
        ifa.mem_rsp_valid_i = 1; ifa.mem_rsp_data_i = 32'h1111_1111;
        cyc();
        ifa.mem_rsp_valid_i = 0;
        n_checks++; if ({a_we, a_busy} !== 2'b00) begin n_fail++; $display("FAIL rsp_idle: got %b expected 00", {a_we, a_busy}); end
    endtask

    task automatic test_misalign();
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b001, 5'd12, 7'b0000011); ifa.alu_result_i = 32'h0000_0001;
        cyc();
        ifa.in_valid_i = 0;
`ifdef WB_MISALIGN_TRAP_EN
        n_checks++; if ({a_trap, a_busy, a_we, ifa.in_ready_o} !== 4'b1001) begin n_fail++; $display("FAIL mis_trap: got %b expected 1001", {a_trap, a_busy, a_we, ifa.in_ready_o}); end
        cyc();
        n_checks++; if (a_trap !== 1'b0) begin n_fail++; $display("FAIL mis_trap_clear: got %b expected 0", a_trap); end
`else
        n_checks++; if ({a_trap, a_busy} !== 2'b01) begin n_fail++; $display("FAIL mis_wait: got %b expected 01", {a_trap, a_busy}); end
        ifa.mem_rsp_valid_i = 1; ifa.mem_rsp_data_i = 32'hFFFF_FFFF;
        cyc();
        ifa.mem_rsp_valid_i = 0;
        n_checks++; if ({a_we, a_rd, a_data} !== {1'b1, 5'd12, 32'h0}) begin n_fail++; $display("FAIL mis_commit: got %b/%0d/%h expected 1/12/0", a_we, a_rd, a_data); end
`endif
        cyc();
    endtask

    task automatic test_rv64();
        logic [2:0]  f3 [3] = '{3'b110, 3'b010, 3'b011};
        logic [4:0]  rd [3] = '{5'd4, 5'd4, 5'd13};
        logic [63:0] ad [3] = '{64'h1004, 64'h1004, 64'h0008};
        logic [63:0] rs [3] = '{64'hF000_0001_0000_0000, 64'hF000_0001_0000_0000, 64'h1122_3344_5566_7788};
        logic [63:0] ex [3] = '{64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0001, 64'h1122_3344_5566_7788};
        for (int i = 0; i < 3; i++) begin
            ifb.in_valid_i = 1; ifb.instr_i = ins(f3[i], rd[i], 7'b0000011); ifb.alu_result_i = ad[i];
            cyc();
            ifb.in_valid_i = 0;
            ifb.mem_rsp_valid_i = 1; ifb.mem_rsp_data_i = rs[i];
            cyc();
            ifb.mem_rsp_valid_i = 0;
            n_checks++; if ({b_we, b_rd, b_data} !== {1'b1, rd[i], ex[i]}) begin n_fail++; $display("FAIL rv64_load%0d: got %b/%0d/%h expected 1/%0d/%h", i, b_we, b_rd, b_data, rd[i], ex[i]); end
        end
        ifb.in_valid_i = 1; ifb.instr_i = ins(3'b000, 5'd14, 7'b0111011); ifb.alu_result_i = 64'h0000_0001_8000_0000;
        cyc();
        ifb.in_valid_i = 0;
        n_checks++; if ({b_we, b_rd, b_data} !== {1'b1, 5'd14, 64'hFFFF_FFFF_8000_0000}) begin n_fail++; $display("FAIL rv64_addw: got %b/%0d/%h expected 1/14/ffffffff80000000", b_we, b_rd, b_data); end
        ifb.in_valid_i = 1; ifb.instr_i = ins(3'b000, 5'd15, 7'b0110011); ifb.alu_result_i = 64'h0000_0001_8000_0000;
        cyc();
        ifb.in_valid_i = 0;
        n_checks++; if ({b_we, b_rd, b_data} !== {1'b1, 5'd15, 64'h0000_0001_8000_0000}) begin n_fail++; $display("FAIL rv64_add: got %b/%0d/%h expected 1/15/0000000180000000", b_we, b_rd, b_data); end
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        ifa.in_valid_i = 1; ifa.instr_i = ins(3'b010, 5'd3, 7'b0000011); ifa.alu_result_i = 32'h0000_0010;
        cyc();
        ifa.in_valid_i = 0;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rstw_busy: got %b expected 1", a_busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({a_busy, a_prd, a_we} !== 7'd0) begin n_fail++; $display("FAIL rstw_idle: got %b/%0d/%b expected 0/0/0", a_busy, a_prd, a_we); end
        cyc();
        rst_n = 1'b1;
        ifa.mem_rsp_valid_i = 1; ifa.mem_rsp_data_i = 32'h7777_7777;
        cyc();
        ifa.mem_rsp_valid_i = 0;
        n_checks++; if ({a_we, a_busy} !== 2'b00) begin n_fail++; $display("FAIL rstw_discard: got %b expected 00", {a_we, a_busy}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu();
        test_load_lb();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_misalign();
        test_rv64();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
